// File: rtl/regfile_bypass_sb_if.sv
// Read/write/scoreboard bundle between decode/issue/writeback (master) and the register file (slave).
interface regfile_bypass_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic              we3;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              set_en;
  logic [ADDR_W-1:0] set_a;
  logic              busy1;
  logic              busy2;
  logic              any_busy;

  modport master (
    output a1, a2, a3, we3, wd3, set_en, set_a,
    input  rd1, rd2, busy1, busy2, any_busy
  );

  modport slave (
    input  a1, a2, a3, we3, wd3, set_en, set_a,
    output rd1, rd2, busy1, busy2, any_busy
  );
endinterface

// File: rtl/regfile_bypass_sb.sv
// 2-read/1-write register file with optional zero register, write-to-read bypass
// and a per-register pending scoreboard for multi-cycle producers.
module regfile_bypass_sb #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 5,
  parameter int unsigned       ZERO_REG  = 1,
  parameter int unsigned       BYPASS    = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic                clk,
  input logic                rst,
  regfile_bypass_sb_if.slave bus
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   pend_q;
  logic [NREG-1:0]   pend_d;

  logic wr_en;
  logic set_ok;
  logic zero1;
  logic zero2;
  logic fwd1;
  logic fwd2;

  assign wr_en  = bus.we3 && !((ZERO_REG != 0) && (bus.a3 == '0));
  assign set_ok = bus.set_en && !((ZERO_REG != 0) && (bus.set_a == '0));

  assign zero1 = (ZERO_REG != 0) && (bus.a1 == '0);
  assign zero2 = (ZERO_REG != 0) && (bus.a2 == '0);
  assign fwd1  = (BYPASS != 0) && bus.we3 && (bus.a1 == bus.a3);
  assign fwd2  = (BYPASS != 0) && bus.we3 && (bus.a2 == bus.a3);

  // Set is applied after clear so a new producer issued at writeback keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (bus.we3) pend_d[bus.a3] = 1'b0;
    if (set_ok)  pend_d[bus.set_a] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= RESET_VAL;
      pend_q <= '0;
    end else begin
      if (wr_en) regs_q[bus.a3] <= bus.wd3;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    bus.rd1   = regs_q[bus.a1];
    bus.busy1 = pend_q[bus.a1];
    if (fwd1) begin
      bus.rd1   = bus.wd3;
      bus.busy1 = 1'b0;
    end
    if (zero1) begin
      bus.rd1   = '0;
      bus.busy1 = 1'b0;
    end
  end

  always_comb begin
    bus.rd2   = regs_q[bus.a2];
    bus.busy2 = pend_q[bus.a2];
    if (fwd2) begin
      bus.rd2   = bus.wd3;
      bus.busy2 = 1'b0;
    end
    if (zero2) begin
      bus.rd2   = '0;
      bus.busy2 = 1'b0;
    end
  end

  assign bus.any_busy = |pend_q;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: two instances (zero-reg+bypass, plain) driven identically
// and compared against a behavioural register/pending model.
module tb_regfile_bypass_sb;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;
  localparam logic [31:0] RV = 32'h1234_5678;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_bypass_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  regfile_bypass_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  regfile_bypass_sb #(
    .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1), .RESET_VAL(RV)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  regfile_bypass_sb #(
    .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0), .RESET_VAL(RV)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per configuration: index 0 = zero-reg+bypass, 1 = plain.
  logic [31:0] m_reg  [2][NR];
  logic        m_pend [2][NR];
  bit          cfg_zero [2] = '{1'b1, 1'b0};
  bit          cfg_byp  [2] = '{1'b1, 1'b0};

  logic        d_rst, d_we, d_se;
  logic [4:0]  d_a1, d_a2, d_a3, d_sa;
  logic [31:0] d_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(int c, logic [4:0] a);
    if (cfg_zero[c] && a == 5'd0) return 32'd0;
    if (cfg_byp[c] && d_we && a == d_a3) return d_wd;
    return m_reg[c][a];
  endfunction

  function automatic logic exp_busy(int c, logic [4:0] a);
    if (cfg_zero[c] && a == 5'd0) return 1'b0;
    if (cfg_byp[c] && d_we && a == d_a3) return 1'b0;
    return m_pend[c][a];
  endfunction

  function automatic logic exp_any(int c);
    logic r = 1'b0;
    for (int i = 0; i < NR; i++) r |= m_pend[c][i];
    return r;
  endfunction

  task automatic check_outputs();
    logic [31:0] g_rd1 [2];
    logic [31:0] g_rd2 [2];
    logic        g_b1  [2];
    logic        g_b2  [2];
    logic        g_any [2];
    g_rd1[0] = bus_a.rd1;   g_rd1[1] = bus_b.rd1;
    g_rd2[0] = bus_a.rd2;   g_rd2[1] = bus_b.rd2;
    g_b1[0]  = bus_a.busy1; g_b1[1]  = bus_b.busy1;
    g_b2[0]  = bus_a.busy2; g_b2[1]  = bus_b.busy2;
    g_any[0] = bus_a.any_busy; g_any[1] = bus_b.any_busy;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("cfg%0d rd1 a1=%0d", c, d_a1), g_rd1[c], exp_rd(c, d_a1));
      check($sformatf("cfg%0d rd2 a2=%0d", c, d_a2), g_rd2[c], exp_rd(c, d_a2));
      check($sformatf("cfg%0d busy1 a1=%0d", c, d_a1), 32'(g_b1[c]), 32'(exp_busy(c, d_a1)));
      check($sformatf("cfg%0d busy2 a2=%0d", c, d_a2), 32'(g_b2[c]), 32'(exp_busy(c, d_a2)));
      check($sformatf("cfg%0d any_busy", c), 32'(g_any[c]), 32'(exp_any(c)));
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < 2; c++) begin
      if (d_rst) begin
        for (int i = 0; i < NR; i++) begin
          m_reg[c][i]  = RV;
          m_pend[c][i] = 1'b0;
        end
      end else begin
        if (d_we && !(cfg_zero[c] && d_a3 == 5'd0)) m_reg[c][d_a3] = d_wd;
        if (d_we) m_pend[c][d_a3] = 1'b0;
        if (d_se && !(cfg_zero[c] && d_sa == 5'd0)) m_pend[c][d_sa] = 1'b1;
      end
    end
  endtask

  // Drive one cycle, check combinational outputs at the falling edge, then clock it in.
  task automatic step(input logic r, input logic we, input logic [4:0] a3,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                      input logic se, input logic [4:0] sa, input bit chk);
    d_rst = r; d_we = we; d_a3 = a3; d_wd = wd; d_a1 = a1; d_a2 = a2; d_se = se; d_sa = sa;
    rst = r;
    bus_a.we3 = we; bus_a.a3 = a3; bus_a.wd3 = wd; bus_a.a1 = a1; bus_a.a2 = a2;
    bus_a.set_en = se; bus_a.set_a = sa;
    bus_b.we3 = we; bus_b.a3 = a3; bus_b.wd3 = wd; bus_b.a1 = a1; bus_b.a2 = a2;
    bus_b.set_en = se; bus_b.set_a = sa;
    #4;
    if (chk) check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset values
    step(0, 0, 0, 0, 0, 7, 0, 0, 1);
    // Basic writes and reads
    step(0, 1, 10, 12, 0, 0, 0, 0, 1);
    step(0, 1, 20, 15, 0, 0, 0, 0, 1);
    step(0, 1, 30, 12, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 10, 20, 0, 0, 1);
    step(0, 0, 0, 0, 30, 10, 0, 0, 1);
    // Zero register: write dropped, never busy
    step(0, 1, 0, 32'hDEAD_BEEF, 1, 2, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Bypass
    step(0, 1, 5, 7, 0, 0, 0, 0, 1);
    step(0, 1, 5, 99, 5, 5, 0, 0, 1);
    step(0, 0, 0, 0, 5, 5, 0, 0, 1);
    // Scoreboard set, forward-clear, clear
    step(0, 0, 0, 0, 0, 0, 1, 8, 1);
    step(0, 0, 0, 0, 8, 8, 0, 0, 1);
    step(0, 1, 8, 3, 8, 1, 0, 0, 1);
    step(0, 0, 0, 0, 8, 8, 0, 0, 1);
    // Set/clear collision: set wins, data still written
    step(0, 0, 0, 0, 0, 0, 1, 4, 1);
    step(0, 1, 4, 6, 4, 4, 1, 4, 1);
    step(0, 0, 0, 0, 4, 4, 0, 0, 1);
    // Reset mid-operation
    step(0, 1, 1, 11, 0, 0, 0, 0, 1);
    step(0, 1, 2, 22, 0, 0, 1, 2, 1);
    step(0, 1, 3, 33, 2, 1, 0, 0, 1);
    step(1, 1, 1, 77, 1, 2, 1, 3, 1);
    step(0, 0, 0, 0, 1, 3, 0, 0, 1);
    step(0, 0, 0, 0, 2, 0, 0, 0, 1);
    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
           rand_addr(), rand_addr(), 1'($urandom_range(0, 2) == 0), rand_addr(), 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
